channel_buffer: RTL

//  Elastic buffer placed directly downstream of a handshake channel_out port.

---
 rtl/channel_pkg.sv | 15 +
 rtl/channel_fifo_mem.sv | 51 +++++
 rtl/channel_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/channel_pkg.sv
// Shared state encodings for the channel_buffer input and output handshake FSMs.
package channel_pkg;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_HOLD = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_WAIT = 2'd2
  } out_state_t;

endpackage

// File: rtl/channel_fifo_mem.sv
// DEPTH x WIDTH circular store with wrapping pointers and an occupancy count.
// The head word is presented combinationally so a pop sees the pre-write head.
module channel_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push && rst) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/channel_buffer.sv
// Elastic buffer between two 4-phase en/ack channels: an input FSM writes
// accepted words into the FIFO, an output FSM re-issues them downstream.
module channel_buffer
  import channel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_en,
  output logic              in_ack,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_en,
  input  logic              out_ack,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  in_state_t        in_state_reg,  in_state_next;
  out_state_t       out_state_reg, out_state_next;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic             in_ack_next;
  logic             out_en_next;
  logic [WIDTH-1:0] out_data_next;

  channel_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_state_reg  <= IN_IDLE;
      out_state_reg <= OUT_IDLE;
      in_ack        <= 1'b0;
      out_en        <= 1'b0;
      out_data      <= '0;
    end else begin
      in_state_reg  <= in_state_next;
      out_state_reg <= out_state_next;
      in_ack        <= in_ack_next;
      out_en        <= out_en_next;
      out_data      <= out_data_next;
    end
  end

  always_comb begin
    in_state_next  = in_state_reg;
    out_state_next = out_state_reg;
    case (in_state_reg)
      IN_IDLE: if (in_en && (count < FULL_COUNT)) in_state_next = IN_HOLD;
      IN_HOLD: if (!in_en) in_state_next = IN_IDLE;
      default: in_state_next = IN_IDLE;
    endcase
    case (out_state_reg)
      OUT_IDLE: if (count != '0) out_state_next = OUT_REQ;
      OUT_REQ:  if (out_ack) out_state_next = OUT_WAIT;
      OUT_WAIT: if (!out_ack) out_state_next = OUT_IDLE;
      default:  out_state_next = OUT_IDLE;
    endcase
  end

  // Exactly one push per request: it only fires on the IN_IDLE -> IN_HOLD step.
  always_comb begin
    push          = 1'b0;
    pop           = 1'b0;
    in_ack_next   = in_ack;
    out_en_next   = out_en;
    out_data_next = out_data;
    case (in_state_reg)
      IN_IDLE: begin
        if (in_en && (count < FULL_COUNT)) begin
          push        = 1'b1;
          in_ack_next = 1'b1;
        end
      end
      IN_HOLD: if (!in_en) in_ack_next = 1'b0;
      default: in_ack_next = 1'b0;
    endcase
    case (out_state_reg)
      OUT_IDLE: begin
        if (count != '0) begin
          pop           = 1'b1;
          out_en_next   = 1'b1;
          out_data_next = head;
        end
      end
      OUT_REQ:  if (out_ack) out_en_next = 1'b0;
      OUT_WAIT: out_en_next = 1'b0;
      default:  out_en_next = 1'b0;
    endcase
  end

endmodule
